// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 16;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_VGA = 2'd0;
  localparam req_id_t REQ_CPU = 2'd1;
  localparam req_id_t REQ_IO  = 2'd2;

  // Round-robin pointer between the two low-priority requesters
  typedef enum logic {
    RR_CPU = 1'b0,
    RR_IO  = 1'b1
  } rr_ptr_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;

  logic          io_req;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;
  logic          io_gnt;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  vga_req, vga_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_addr, io_wdata,
    input  mem_rdata,
    output vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, io_gnt, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side
  modport master (
    output vga_req, vga_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_addr, io_wdata,
    output mem_rdata,
    input  vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, io_gnt, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_rd_tag_pipe.sv
// Shift register carrying {valid, id} for each issued read until its data returns.
module mem_rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stages [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single-port data memory: VGA read, CPU load/store, IO write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_MAX   = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

  logic          vga_gnt_q, cpu_gnt_q, io_gnt_q;
  logic          en_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  req_id_t       id_q;

  logic [SW-1:0] cpu_wait_q, io_wait_q;
  rr_ptr_t       rr_q;

  logic vga_elig, cpu_elig, io_elig;
  logic cpu_starved, io_starved;
  logic win_vga, win_cpu, win_io;

  rd_tag_t tag_in, tag_out;

  // A requester whose grant is showing this cycle is masked so a held req is not granted twice
  always_comb begin
    vga_elig    = bus.vga_req & ~vga_gnt_q;
    cpu_elig    = bus.cpu_req & ~cpu_gnt_q;
    io_elig     = bus.io_req  & ~io_gnt_q;
    cpu_starved = cpu_elig & (cpu_wait_q == SMAX);
    io_starved  = io_elig  & (io_wait_q  == SMAX);
    win_vga     = 1'b0;
    win_cpu     = 1'b0;
    win_io      = 1'b0;
    if (cpu_starved && io_starved) begin
      win_cpu = (rr_q == RR_CPU);
      win_io  = (rr_q == RR_IO);
    end else if (cpu_starved) begin
      win_cpu = 1'b1;
    end else if (io_starved) begin
      win_io = 1'b1;
    end else if (vga_elig) begin
      win_vga = 1'b1;
    end else if (cpu_elig && io_elig) begin
      win_cpu = (rr_q == RR_CPU);
      win_io  = (rr_q == RR_IO);
    end else if (cpu_elig) begin
      win_cpu = 1'b1;
    end else if (io_elig) begin
      win_io = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_gnt_q <= 1'b0;
      cpu_gnt_q <= 1'b0;
      io_gnt_q  <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      id_q      <= REQ_VGA;
    end else begin
      vga_gnt_q <= win_vga;
      cpu_gnt_q <= win_cpu;
      io_gnt_q  <= win_io;
      en_q      <= win_vga | win_cpu | win_io;
      we_q      <= (win_cpu & bus.cpu_we) | win_io;
      id_q      <= win_cpu ? REQ_CPU : (win_io ? REQ_IO : REQ_VGA);
      addr_q    <= win_vga ? bus.vga_addr :
                   win_cpu ? bus.cpu_addr :
                   win_io  ? bus.io_addr  : '0;
      wdata_q   <= win_cpu ? bus.cpu_wdata :
                   win_io  ? bus.io_wdata  : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_wait_q <= '0;
      io_wait_q  <= '0;
    end else begin
      if (!bus.cpu_req || win_cpu || cpu_gnt_q) begin
        cpu_wait_q <= '0;
      end else if (cpu_wait_q != SMAX) begin
        cpu_wait_q <= cpu_wait_q + SW'(1);
      end
      if (!bus.io_req || win_io || io_gnt_q) begin
        io_wait_q <= '0;
      end else if (io_wait_q != SMAX) begin
        io_wait_q <= io_wait_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= RR_CPU;
    end else if (win_cpu) begin
      rr_q <= RR_IO;
    end else if (win_io) begin
      rr_q <= RR_CPU;
    end
  end

  // Writes enter the pipe as null tags so read returns stay aligned to issue order
  assign tag_in = '{valid: en_q & ~we_q, id: id_q};

  mem_rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.vga_gnt    = vga_gnt_q;
  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.io_gnt     = io_gnt_q;
  assign bus.vga_rvalid = tag_out.valid && (tag_out.id == REQ_VGA);
  assign bus.cpu_rvalid = tag_out.valid && (tag_out.id == REQ_CPU);
  assign bus.rdata      = bus.mem_rdata;
  assign bus.mem_en     = en_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned RL   = 3;
  localparam int          SMAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .READ_LATENCY (RL),
    .STARVE_MAX   (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[0], a[15:1]};
  endfunction

  // Physical memory with READ_LATENCY-cycle read pipeline
  logic [15:0] mem [logic [15:0]];
  logic [15:0] rd_pipe [RL];

  function automatic logic [15:0] phys_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? phys_rd(bus.mem_addr) : 16'hdead;
    for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RL-1];

  // Reference model: expected grant/issue per cycle, and a queue of expected read returns
  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } rd_exp_t;

  logic [15:0] ref_mem [logic [15:0]];
  rd_exp_t     rq [$];
  int          cyc        = 0;
  int          last_win   = -1;
  int          cpu_wait   = 0;
  int          io_wait    = 0;
  bit          prefer_cpu = 1'b1;
  bit          exp_en     = 1'b0;
  bit          exp_we     = 1'b0;
  logic [15:0] exp_addr   = '0;
  logic [15:0] exp_wdata  = '0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    int w;
    bit v_ok, c_ok, i_ok, c_st, i_st;
    cyc++;
    if (!rst) begin
      last_win   = -1;
      cpu_wait   = 0;
      io_wait    = 0;
      prefer_cpu = 1'b1;
      exp_en     = 1'b0;
      exp_we     = 1'b0;
      rq.delete();
    end else begin
      v_ok = bus.vga_req && last_win != 0;
      c_ok = bus.cpu_req && last_win != 1;
      i_ok = bus.io_req  && last_win != 2;
      c_st = c_ok && cpu_wait == SMAX;
      i_st = i_ok && io_wait == SMAX;
      if (c_st && i_st)      w = prefer_cpu ? 1 : 2;
      else if (c_st)         w = 1;
      else if (i_st)         w = 2;
      else if (v_ok)         w = 0;
      else if (c_ok && i_ok) w = prefer_cpu ? 1 : 2;
      else if (c_ok)         w = 1;
      else if (i_ok)         w = 2;
      else                   w = -1;

      cpu_wait = (!bus.cpu_req || w == 1 || last_win == 1) ? 0 : (cpu_wait < SMAX ? cpu_wait + 1 : SMAX);
      io_wait  = (!bus.io_req  || w == 2 || last_win == 2) ? 0 : (io_wait  < SMAX ? io_wait  + 1 : SMAX);
      if (w == 1) prefer_cpu = 1'b0;
      if (w == 2) prefer_cpu = 1'b1;

      exp_en    = (w >= 0);
      exp_we    = (w == 1 && bus.cpu_we) || w == 2;
      exp_addr  = (w == 0) ? bus.vga_addr : (w == 1) ? bus.cpu_addr : (w == 2) ? bus.io_addr : 16'h0;
      exp_wdata = (w == 1) ? bus.cpu_wdata : (w == 2) ? bus.io_wdata : 16'h0;
      if (exp_en && !exp_we) rq.push_back('{due: cyc + int'(RL), id: w, data: ref_rd(exp_addr)});
      if (exp_en && exp_we) ref_mem[exp_addr] = exp_wdata;
      last_win = w;
    end
  end

  always @(negedge clk) begin
    int          rv;
    logic [15:0] dexp;
    if (!rst) begin
      check("rst_gnt", {bus.vga_gnt, bus.cpu_gnt, bus.io_gnt}, 0);
      check("rst_en", {bus.mem_en, bus.mem_we}, 0);
      check("rst_rvalid", {bus.vga_rvalid, bus.cpu_rvalid}, 0);
    end else begin
      check("vga_gnt", bus.vga_gnt, last_win == 0);
      check("cpu_gnt", bus.cpu_gnt, last_win == 1);
      check("io_gnt", bus.io_gnt, last_win == 2);
      check("one_gnt", 32'($countones({bus.vga_gnt, bus.cpu_gnt, bus.io_gnt}) <= 1), 1);
      check("mem_en", bus.mem_en, exp_en);
      if (exp_en) begin
        check("mem_we", bus.mem_we, exp_we);
        check("mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      rv   = -1;
      dexp = '0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        rv   = rq[0].id;
        dexp = rq[0].data;
        void'(rq.pop_front());
      end
      check("vga_rvalid", bus.vga_rvalid, rv == 0);
      check("cpu_rvalid", bus.cpu_rvalid, rv == 1);
      if (rv >= 0) check("rdata", bus.rdata, dexp);
    end
  end

  // Requester driver: a granted request is dropped unless that requester is holding
  bit hold_v = 1'b0, hold_c = 1'b0, hold_i = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.vga_gnt && !hold_v) bus.vga_req = 1'b0;
    if (bus.cpu_gnt && !hold_c) bus.cpu_req = 1'b0;
    if (bus.io_gnt  && !hold_i) bus.io_req  = 1'b0;
  endtask

  task automatic release_all();
    hold_v = 1'b0; hold_c = 1'b0; hold_i = 1'b0;
    bus.vga_req = 1'b0; bus.cpu_req = 1'b0; bus.io_req = 1'b0;
    repeat (RL + 2) step();
  endtask

  initial begin
    int          got, lat, prev, gv, gc, rvv, rvc;
    bit          seen;
    logic [15:0] rd, dv, dc;

    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.io_req  = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset release
    seen = 1'b0;
    repeat (5) begin
      step();
      seen |= bus.vga_gnt | bus.cpu_gnt | bus.io_gnt | bus.mem_en | bus.vga_rvalid | bus.cpu_rvalid;
    end
    check("idle_quiet", seen, 0);

    // CPU load from 0x0004 (holds 0x0002)
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0004;
    step();
    check("ld_gnt", bus.cpu_gnt, 1);
    check("ld_en", bus.mem_en, 1);
    check("ld_addr", bus.mem_addr, 16'h0004);
    lat = 0; rd = '0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (bus.cpu_rvalid) begin lat = n; rd = bus.rdata; break; end
    end
    check("ld_latency", lat, RL);
    check("ld_data", rd, 16'h0002);

    // VGA read and CPU store raised together
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0020;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h0007;
    step();
    check("pri_vga_first", bus.vga_gnt, 1);
    check("pri_cpu_waits", bus.cpu_gnt, 0);
    step();
    check("pri_cpu_next", bus.cpu_gnt, 1);
    repeat (RL + 2) step();
    check("store_mem", phys_rd(16'h0010), 16'h0007);

    // VGA held continuously with a held CPU request
    hold_v = 1'b1; hold_c = 1'b1;
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0021;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0022;
    got = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (bus.cpu_gnt) begin got = n; break; end
    end
    check("cpu_not_starved", got > 0 && got <= SMAX + 2, 1);
    repeat (10) step();
    release_all();

    // CPU and IO held together: grants alternate
    hold_c = 1'b1; hold_i = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 16'h1234;
    bus.io_req  = 1'b1; bus.io_addr = 16'h0041; bus.io_wdata = 16'h5678;
    prev = -1;
    for (int n = 0; n < 10; n++) begin
      int g;
      step();
      g = bus.cpu_gnt ? 1 : (bus.io_gnt ? 2 : -1);
      if (prev >= 0) begin
        check("rr_every_cycle", g >= 0, 1);
        check("rr_alternate", g != prev, 1);
      end
      if (g >= 0) prev = g;
    end
    release_all();

    // VGA read at N, CPU read at N+1: returns RL cycles after each issue
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
    step();
    gv = bus.vga_gnt ? cyc : -100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0101;
    step();
    gc = bus.cpu_gnt ? cyc : -100;
    rvv = -1; rvc = -1; dv = '0; dc = '0;
    for (int n = 0; n < 10; n++) begin
      if (bus.vga_rvalid) begin rvv = cyc; dv = bus.rdata; end
      if (bus.cpu_rvalid) begin rvc = cyc; dc = bus.rdata; end
      step();
    end
    check("pipe_vga_cycle", rvv, gv + int'(RL));
    check("pipe_cpu_cycle", rvc, gc + int'(RL));
    check("pipe_vga_data", dv, init_val(16'h0100));
    check("pipe_cpu_data", dc, init_val(16'h0101));

    // Reset asserted while a read is in flight
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
    step();
    check("rst_rd_gnt", bus.cpu_gnt, 1);
    step();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    seen = 1'b0;
    repeat (RL + 3) begin
      step();
      seen |= bus.cpu_rvalid | bus.vga_rvalid;
    end
    check("rst_drops_read", seen, 0);

    // Random traffic with occasional withdrawals
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!bus.vga_req) begin
        if ($urandom_range(99) < 55) begin
          bus.vga_req = 1'b1; bus.vga_addr = 16'($urandom_range(63));
        end
      end else if ($urandom_range(39) == 0) bus.vga_req = 1'b0;
      if (!bus.cpu_req) begin
        if ($urandom_range(99) < 50) begin
          bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(1));
          bus.cpu_addr = 16'($urandom_range(63)); bus.cpu_wdata = 16'($urandom);
        end
      end else if ($urandom_range(39) == 0) bus.cpu_req = 1'b0;
      if (!bus.io_req) begin
        if ($urandom_range(99) < 35) begin
          bus.io_req = 1'b1; bus.io_addr = 16'($urandom_range(63)); bus.io_wdata = 16'($urandom);
        end
      end else if ($urandom_range(39) == 0) bus.io_req = 1'b0;
    end
    release_all();
    check("reads_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
